// File: rtl/oci_dct_trace_capture.sv
// oci_dct_trace_capture: per-core OCI DCT trace FIFO with test-end sequencing.
// Optional capture timestamps are enabled by defining OCI_TRACE_TIMESTAMP_EN.
module oci_dct_trace_capture #(
    parameter  int DCT_WIDTH   = 30,
    parameter  int COUNT_WIDTH = 4,
    parameter  int DEPTH       = 16,
    parameter  int TS_WIDTH    = 16,
    parameter  int DROP_WIDTH  = 8,
    localparam int PTR_W       = $clog2(DEPTH),
`ifdef OCI_TRACE_TIMESTAMP_EN
    localparam int TS_EN       = 1,
`else
    localparam int TS_EN       = 0,
`endif
    localparam int ENTRY_W     = COUNT_WIDTH + DCT_WIDTH + TS_EN * TS_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DCT_WIDTH-1:0]   dct_buffer,
    input  logic [COUNT_WIDTH-1:0] dct_count,
    input  logic                   test_ending,
    input  logic                   test_has_ended,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [ENTRY_W-1:0]     rd_data,
    output logic [PTR_W:0]         level,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count,
    output logic                   done,
    output logic [1:0]             state
);

    typedef enum logic [1:0] {
        CAPTURE = 2'b00,
        DRAIN   = 2'b01,
        DONE    = 2'b10
    } state_t;

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_LVL  = (PTR_W+1)'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         level_q;
    logic [COUNT_WIDTH-1:0] prev_count;
    logic                   overflow_q;
    logic [DROP_WIDTH-1:0]  drop_q;
    logic                   capture_en;
    logic                   is_done;
    logic                   abort;
    logic                   cap_event;
    logic                   pop;
    logic                   full;
    logic                   wr_en;
    logic                   drop;
    logic [ENTRY_W-1:0]     wr_entry;

    // Abort overrides everything, including a capture in the same cycle.
    assign abort     = test_has_ended;
    assign cap_event = capture_en && !abort
                    && (dct_count != '0)
                    && (dct_count != prev_count);
    assign rd_valid  = (level_q != '0) && !is_done;
    assign pop       = rd_valid && rd_ready;
    assign full      = (level_q == FULL_LVL);
    assign wr_en     = cap_event && (!full || pop);
    assign drop      = cap_event && full && !pop;

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_WIDTH'(1);
    end

    assign wr_entry = {ts_q, dct_count, dct_buffer};
`else
    assign wr_entry = {dct_count, dct_buffer};
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (abort) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({wr_en, pop})
                2'b10:   level_q <= level_q + ONE_LVL;
                2'b01:   level_q <= level_q - ONE_LVL;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_count <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            prev_count <= dct_count;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= CAPTURE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CAPTURE: if (test_ending) state_d = DRAIN;
            DRAIN: begin
                if (level_q == '0 || (level_q == ONE_LVL && pop))
                    state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = DONE;
        endcase
        if (abort) state_d = DONE;
    end

    always_comb begin
        capture_en = (state_q == CAPTURE);
        is_done    = (state_q == DONE);
    end

    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign done       = is_done;
    assign state      = state_q;

endmodule
